// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: op selects, stall polarity, FSM states.
// Optional single-cycle multiply is selected by MDU_FAST_MUL_EN in mdu_ctrl.
package mdu_ctrl_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int   EX_STALL_BIT = 3;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_DIV_RUN = 2'b10,
    ST_DONE    = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// Restoring divider: one quotient bit per cycle from the MSB; quo_nxt/rem_nxt are final while done=1.
// Latency DATA_W cycles after start; no backpressure, clear abandons the operation.
module mdu_ctrl_div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quo_nxt,
  output logic [DATA_W-1:0] rem_nxt
);

  localparam int CNT_W = $clog2(DATA_W);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;
  logic              fits;

  // quo_q starts as the dividend and is shifted out MSB-first as quotient bits shift in.
  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign fits    = ~diff[DATA_W];
  assign rem_nxt = fits ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign quo_nxt = {quo_q[DATA_W-2:0], fits};
  assign done    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      dvs_q  <= divisor;
      quo_q  <= dividend;
      rem_q  <= '0;
    end else if (busy_q) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer for EX; MDU_FAST_MUL_EN selects a single-cycle native multiply.
// Latency DATA_W+1 cycles (multiply 1 with MDU_FAST_MUL_EN); stalls IF..EX while busy, holds result while stall[3].
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic               op_valid,
  input  logic [1:0]         op_sel,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  output logic               stallreq_for_mdu,
  output logic               result_valid,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o
);

  localparam int PROD_W = 2 * DATA_W;

  mdu_state_e        state_q, state_d;
  logic              accept;
  logic              is_div;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic              neg_res_q, neg_rem_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              div_done;
  logic [DATA_W-1:0] div_quo, div_rem;
  logic              mul_last;
  logic [PROD_W-1:0] prod_fix;
  logic              stall_unused;

  assign stall_unused = ^{stall[STALL_W-1:EX_STALL_BIT+1], stall[EX_STALL_BIT-1:0]};

  assign is_div = op_sel[1];
  assign accept = (state_q == ST_IDLE) && op_valid && !flush;
  assign a_abs  = (op_sel[0] && src_a[DATA_W-1]) ? -src_a : src_a;
  assign b_abs  = (op_sel[0] && src_b[DATA_W-1]) ? -src_b : src_b;

`ifndef MDU_FAST_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);

  logic [CNT_W-1:0]  mul_cnt_q;
  logic [PROD_W-1:0] mcand_q, prod_q, prod_nxt;
  logic [DATA_W-1:0] mplier_q;

  assign prod_nxt = mplier_q[0] ? prod_q + mcand_q : prod_q;
  assign mul_last = (state_q == ST_MUL_RUN) && (mul_cnt_q == CNT_W'(DATA_W - 1));
  assign prod_fix = neg_res_q ? -prod_nxt : prod_nxt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mul_cnt_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
    end else if (accept && !is_div) begin
      mul_cnt_q <= '0;
      mcand_q   <= {{DATA_W{1'b0}}, a_abs};
      mplier_q  <= b_abs;
      prod_q    <= '0;
    end else if (state_q == ST_MUL_RUN) begin
      mul_cnt_q <= mul_cnt_q + CNT_W'(1);
      mcand_q   <= mcand_q << 1;
      mplier_q  <= mplier_q >> 1;
      prod_q    <= prod_nxt;
    end
  end
`else
  logic [PROD_W-1:0] ext_a, ext_b;

  // Sign-extended operands make the truncated product exact for both MULT and MULTU.
  assign ext_a    = {{DATA_W{op_sel[0] & src_a[DATA_W-1]}}, src_a};
  assign ext_b    = {{DATA_W{op_sel[0] & src_b[DATA_W-1]}}, src_b};
  assign prod_fix = ext_a * ext_b;
  assign mul_last = accept && !is_div;
`endif

  mdu_ctrl_div_core #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .start    (accept && is_div),
    .dividend (a_abs),
    .divisor  (b_abs),
    .done     (div_done),
    .quo_nxt  (div_quo),
    .rem_nxt  (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        neg_res_q <= op_sel[0] & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
        neg_rem_q <= op_sel[0] & src_a[DATA_W-1];
      end
      if (mul_last) begin
        {hi_q, lo_q} <= prod_fix;
      end else if (div_done) begin
        hi_q <= neg_rem_q ? -div_rem : div_rem;
        lo_q <= neg_res_q ? -div_quo : div_quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    stallreq_for_mdu = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stallreq_for_mdu = op_valid;
        if (op_valid) begin
`ifdef MDU_FAST_MUL_EN
          state_d = is_div ? ST_DIV_RUN : ST_DONE;
`else
          state_d = is_div ? ST_DIV_RUN : ST_MUL_RUN;
`endif
        end
      end
`ifndef MDU_FAST_MUL_EN
      ST_MUL_RUN: begin
        stallreq_for_mdu = 1'b1;
        if (mul_last) state_d = ST_DONE;
      end
`endif
      ST_DIV_RUN: begin
        stallreq_for_mdu = 1'b1;
        if (div_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        // The instruction still in EX here is the one completing; it is never re-accepted.
        if (stall[EX_STALL_BIT] == NO_STOP) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign result_valid = (state_q == ST_DONE);
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from EX, runs an iterative shift-add multiplier or restoring divider, and raises a stall request while busy.
- Presents the 64-bit {hi,lo} result for exactly one EX advance, for the HI/LO write path.

Parameters:
- DATA_W, 32, operand width; also the iteration count.
- STALL_W, 6, width of the pipeline stall bus (equals `StallBus).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; abandons any operation
- stall  in  STALL_W  global stall bus; stall[3] is the EX-stage hold
- op_valid  in  1  EX holds an MDU instruction this cycle
- op_sel  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  in  DATA_W  rs value (multiplicand/dividend)
- src_b  in  DATA_W  rt value (multiplier/divisor)
- stallreq_for_mdu  out  1  request to hold IF..EX
- result_valid  out  1  result is valid for the instruction in EX
- hi_o  out  DATA_W  product[63:32] / remainder
- lo_o  out  DATA_W  product[31:0] / quotient

Behaviour:
- Reset/flush: state=IDLE, counter=0, all outputs 0. Flush wins over every other event in the same cycle.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE:
  - With op_valid=1: latch operands as absolute values when signed (op_sel[0]=1), record the result signs, counter=0, then go to MUL_RUN or DIV_RUN.
  - stallreq_for_mdu=op_valid, combinational, so the acceptance cycle already stalls.
- MUL_RUN: one shift-add step per cycle on a 64-bit accumulator. After DATA_W steps (counter==DATA_W-1), go to DONE.
- DIV_RUN: restoring, one quotient bit per cycle from the MSB. After DATA_W steps, go to DONE.
- RUN states: stallreq_for_mdu=1, result_valid=0.
- Sign fix-up (on entry to DONE, registered):
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Latency: acceptance edge + DATA_W run cycles; DONE is the (DATA_W+1)th cycle after acceptance (33 for the default).
- DONE:
  - result_valid=1, hi_o/lo_o stable, stallreq_for_mdu=0.
  - If stall[3]==`NoStop, return to IDLE next edge. The same-cycle op_valid is the completing instruction and is not re-accepted.
  - If stall[3]==`Stop (other stall source), hold DONE and the outputs until it releases.
- Outputs hold their last value in IDLE; consumers use result_valid only.
- Divide by zero: quotient 0xFFFF_FFFF, remainder = dividend (unsigned raw). The signed fix-up applies as for any other operand.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0. No trap.
- op_valid while in a RUN state or DONE is ignored; operands are latched only in IDLE.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle native multiply. IDLE goes to DONE directly; the result is valid the cycle after acceptance (latency 1). The MUL_RUN state is not compiled.
- Undefined: MULT/MULTU use the iterative 32-cycle path described above.
- Division is unaffected either way.

Decomposition:
- Shared defines (lib/defines.vh):
  - MDU op_sel encodings.
  - State encodings (2-bit).
  - `StallBus, `Stop, `NoStop (already present).
- Sub-module mdu_div_core: the restoring divider datapath (operand registers, partial remainder, quotient shift, counter), with a start/done handshake.
- mdu_ctrl owns the FSM, sign handling, the multiplier, and the stall/result interface.

Test Plan:
- MULTU 0xFFFF_FFFF * 0xFFFF_FFFF, stall=0 -> stallreq high 33 cycles; result_valid 1 cycle; hi=0xFFFF_FFFE, lo=0x0000_0001.
- MULT -7 * 3 -> {hi,lo}=0xFFFF_FFFF_FFFF_FFEB. With MDU_FAST_MUL_EN -> result_valid on the 1st cycle after acceptance.
- DIV -7 / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 100 / 0 -> lo=0xFFFF_FFFF, hi=100.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0, no hang, back to IDLE.
- Hold stall[3]=`Stop for 3 cycles while in DONE -> result_valid and hi/lo held 4 cycles, no restart.
- flush at run cycle 10, and separately rst at run cycle 20 -> next cycle IDLE, stallreq=0, result_valid=0. A new DIVU 9 / 4 then yields lo=2, hi=1.
